xbar_master_interface: RTL and testbench
========================================

XBAR_MASTER_INTERFACE -- requirements
Module: xbar_master_interface

Interface
REQ-001 SHALL have parameters: ID_WIDTH 4 (master-side ID width); IDS_WIDTH 8 (outer-slave ID width, SHALL be >= ID_WIDTH+MW); ADDR_WIDTH 32; LEN_WIDTH 4; SIZE_WIDTH 3; DATA_WIDTH 32; STRB_WIDTH 4; masters 2 (number of master interfaces); i_am_slave_number 0 (index of this outer slave). MW = max(1, $clog2(masters)).
REQ-002 SHALL have one clock and an asynchronous active-high reset; ports listed as name, direction, width, meaning:
ACLK  input  1  clock, all state on rising edge
ARESET  input  1  asynchronous active-high reset
AR_REQ_M  input  [masters]  master m has an AR at its FIFO head
AR_DEST_M  input  [masters][$clog2(masters)... slave idx width]  decoded destination slave per master
AR_PAYLOAD_M  input  [masters][ID+ADDR+LEN+SIZE+2]  {ARID,ARADDR,ARLEN,ARSIZE,ARBURST} per master
AR_GRANT_M  output  [masters]  one-cycle pop pulse to master m's AR FIFO
AW_REQ_M / AW_DEST_M / AW_PAYLOAD_M / AW_GRANT_M  same shapes as the AR group, for AW
W_REQ_M  input  [masters]  master m has a W beat at its FIFO head
W_PAYLOAD_M  input  [masters][DATA+STRB+1]  {WDATA,WSTRB,WLAST}
W_GRANT_M  output  [masters]  one-cycle pop pulse to master m's W FIFO
R_VALID_X / R_READY_X  output 1 / input [masters]  returned R beat valid; per-master accept
R_DEST_X  output  MW  destination master of the returned R beat
R_PAYLOAD_X  output  ID+DATA+2+1  {RID,RDATA,RRESP,RLAST}
B_VALID_X / B_READY_X / B_DEST_X / B_PAYLOAD_X  same as the R group; payload {BID,BRESP}
AR*_S, AW*_S, W*_S  output  AXI widths  registered AXI request channels to outer slave; *READY_S inputs
R*_S, B*_S  input  AXI widths  AXI response channels; RREADY_S, BREADY_S outputs

Function
REQ-003 AR arbitration SHALL be round-robin over masters m with AR_REQ_M[m] & AR_DEST_M[m]==i_am_slave_number; pointer resets to 0 and moves to (grantee+1) mod masters after each grant.
REQ-004 A grant SHALL occur only when the AR output register is empty, or is being emptied in the same cycle (ARVALID_S & ARREADY_S); back-to-back beats SHALL sustain 1 per cycle.
REQ-005 On an AR grant, AR_GRANT_M[m] SHALL pulse for exactly one cycle and the register SHALL load the payload with ARID_S = {zero pad, m[MW-1:0], ARID}; ARVALID_S rises the next cycle and holds stable until ARREADY_S.
REQ-006 AW SHALL use the same arbitration, register and ID rules, with an independent pointer, and SHALL be granted only when the W FSM is IDLE.
REQ-007 The W FSM SHALL have states IDLE, ACTIVE and LAST.
- IDLE -> ACTIVE on an AW grant; w_owner <= grantee.
- ACTIVE: when W_REQ_M[w_owner] is set and the W register is free or draining, pulse W_GRANT_M[w_owner] and load the beat. If the beat has WLAST=1 -> LAST.
- LAST: no W grants; -> IDLE when WVALID_S & WREADY_S & WLAST_S.
REQ-008 W_REQ_M of non-owners, and of all masters in IDLE/LAST, SHALL be ignored.
REQ-009 RREADY_S SHALL equal ~r_valid | (R_READY_X[r_dest] & r_valid). On an R handshake the register SHALL load; r_dest = RID_S[ID_WIDTH +: MW]; RID = RID_S[ID_WIDTH-1:0]. Fill and drain in the same cycle SHALL be allowed.
REQ-010 A returned beat whose decoded dest >= masters SHALL be accepted and discarded: R_VALID_X and B_VALID_X stay 0.
REQ-011 The B path SHALL behave as REQ-009/REQ-010 using BID_S.
REQ-012 All *_GRANT_M outputs SHALL be zero in any cycle without a grant; at most one bit per channel SHALL be set.

Reset
REQ-013 ARESET SHALL asynchronously clear ARVALID_S, AWVALID_S, WVALID_S, R_VALID_X, B_VALID_X and all grants. It SHALL also force the FSM to IDLE, zero both pointers, and drive RREADY_S=1 and BREADY_S=1 after reset.
REQ-014 Reset mid-burst SHALL abandon the transaction; no grant SHALL issue while ARESET=1.

Verification
REQ-015 masters=2; both assert AR to slave 0 every cycle, ARREADY_S=1 -> grants alternate M0,M1,M0,…; ARID_S[5:4] = 0,1,0.
REQ-016 M1 issues AW with AWLEN=3, then 4 W beats; M0 raises AW during the burst -> M0's AW is not granted until the cycle after WLAST_S handshakes.
REQ-017 ARREADY_S held 0 for 5 cycles with ARVALID_S=1 -> ARADDR_S stable, no AR grants; ARREADY_S=1 -> transfer, and a new grant in the same cycle.
REQ-018 RID_S=0x13, RVALID_S=1, R_READY_X=0 -> R_VALID_X=1, R_DEST_X=1, RID=3; RREADY_S=0 until R_READY_X[1]=1.
REQ-019 BID_S with dest field 3 (masters=2) -> BREADY_S=1 and B_VALID_X stays 0.
REQ-020 ARESET pulse in W state ACTIVE -> all valids 0 within the same cycle and FSM IDLE; a fresh AW is granted 1 cycle after release.

Source files
------------

// File: rtl/xbar_master_interface.sv
// Outer-slave port of an AXI crossbar: round-robin AR/AW arbitration over masters,
// W routing locked to the AW owner, and R/B return steering by the ID prefix.
module xbar_master_interface #(
    parameter int ID_WIDTH          = 4,
    parameter int IDS_WIDTH         = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int LEN_WIDTH         = 4,
    parameter int SIZE_WIDTH        = 3,
    parameter int DATA_WIDTH        = 32,
    parameter int STRB_WIDTH        = 4,
    parameter int masters           = 2,
    parameter int i_am_slave_number = 0,
    localparam int MW = (masters > 1) ? $clog2(masters) : 1,
    localparam int AP = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2,
    localparam int WP = DATA_WIDTH + STRB_WIDTH + 1,
    localparam int RP = ID_WIDTH + DATA_WIDTH + 3,
    localparam int BP = ID_WIDTH + 2,
    localparam int HW = IDS_WIDTH - ID_WIDTH
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [masters-1:0]                AR_REQ_M,
    input  logic [masters-1:0][MW-1:0]        AR_DEST_M,
    input  logic [masters-1:0][AP-1:0]        AR_PAYLOAD_M,
    output logic [masters-1:0]                AR_GRANT_M,
    input  logic [masters-1:0]                AW_REQ_M,
    input  logic [masters-1:0][MW-1:0]        AW_DEST_M,
    input  logic [masters-1:0][AP-1:0]        AW_PAYLOAD_M,
    output logic [masters-1:0]                AW_GRANT_M,
    input  logic [masters-1:0]                W_REQ_M,
    input  logic [masters-1:0][WP-1:0]        W_PAYLOAD_M,
    output logic [masters-1:0]                W_GRANT_M,
    output logic                              R_VALID_X,
    input  logic [masters-1:0]                R_READY_X,
    output logic [MW-1:0]                     R_DEST_X,
    output logic [RP-1:0]                     R_PAYLOAD_X,
    output logic                              B_VALID_X,
    input  logic [masters-1:0]                B_READY_X,
    output logic [MW-1:0]                     B_DEST_X,
    output logic [BP-1:0]                     B_PAYLOAD_X,
    output logic [IDS_WIDTH-1:0]              ARID_S,
    output logic [ADDR_WIDTH-1:0]             ARADDR_S,
    output logic [LEN_WIDTH-1:0]              ARLEN_S,
    output logic [SIZE_WIDTH-1:0]             ARSIZE_S,
    output logic [1:0]                        ARBURST_S,
    output logic                              ARVALID_S,
    input  logic                              ARREADY_S,
    output logic [IDS_WIDTH-1:0]              AWID_S,
    output logic [ADDR_WIDTH-1:0]             AWADDR_S,
    output logic [LEN_WIDTH-1:0]              AWLEN_S,
    output logic [SIZE_WIDTH-1:0]             AWSIZE_S,
    output logic [1:0]                        AWBURST_S,
    output logic                              AWVALID_S,
    input  logic                              AWREADY_S,
    output logic [DATA_WIDTH-1:0]             WDATA_S,
    output logic [STRB_WIDTH-1:0]             WSTRB_S,
    output logic                              WLAST_S,
    output logic                              WVALID_S,
    input  logic                              WREADY_S,
    input  logic [IDS_WIDTH-1:0]              RID_S,
    input  logic [DATA_WIDTH-1:0]             RDATA_S,
    input  logic [1:0]                        RRESP_S,
    input  logic                              RLAST_S,
    input  logic                              RVALID_S,
    output logic                              RREADY_S,
    input  logic [IDS_WIDTH-1:0]              BID_S,
    input  logic [1:0]                        BRESP_S,
    input  logic                              BVALID_S,
    output logic                              BREADY_S
);

    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_LAST} w_state_t;

    w_state_t          r_wstate;
    logic [MW-1:0]     r_ar_ptr, r_aw_ptr, r_w_owner;
    logic [masters-1:0] w_ar_elig, w_aw_elig;
    logic [MW:0]       w_ar_pick, w_aw_pick;
    logic [MW-1:0]     w_ar_idx, w_aw_idx;
    logic              w_ar_go, w_aw_go, w_w_go;
    logic [AP-1:0]     w_ar_pl, w_aw_pl;
    logic [WP-1:0]     w_w_pl;
    logic [HW-1:0]     w_r_hi, w_b_hi;
    logic              w_r_keep, w_b_keep;

    // Returns {found, index}; search starts at ptr and wraps.
    function automatic logic [MW:0] rr_pick(input logic [masters-1:0] req, input logic [MW-1:0] ptr);
        logic [MW:0] res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 0; i < masters; i++) begin
            k = 32'(ptr) + i;
            if (k >= masters) k = k - masters;
            if (!res[MW] && req[MW'(k)]) res = {1'b1, MW'(k)};
        end
        return res;
    endfunction

    function automatic logic [MW-1:0] rr_next(input logic [MW-1:0] idx);
        return (32'(idx) == masters - 1) ? '0 : idx + 1'b1;
    endfunction

    for (genvar g = 0; g < masters; g++) begin : g_elig
        assign w_ar_elig[g] = AR_REQ_M[g] & (AR_DEST_M[g] == MW'(i_am_slave_number));
        assign w_aw_elig[g] = AW_REQ_M[g] & (AW_DEST_M[g] == MW'(i_am_slave_number));
    end

    assign w_ar_pick = rr_pick(w_ar_elig, r_ar_ptr);
    assign w_aw_pick = rr_pick(w_aw_elig, r_aw_ptr);
    assign w_ar_idx  = w_ar_pick[MW-1:0];
    assign w_aw_idx  = w_aw_pick[MW-1:0];
    assign w_ar_pl   = AR_PAYLOAD_M[w_ar_idx];
    assign w_aw_pl   = AW_PAYLOAD_M[w_aw_idx];
    assign w_w_pl    = W_PAYLOAD_M[r_w_owner];

    assign w_ar_go = ~ARESET & w_ar_pick[MW] & (~ARVALID_S | ARREADY_S);
    assign w_aw_go = ~ARESET & w_aw_pick[MW] & (~AWVALID_S | AWREADY_S) & (r_wstate == W_IDLE);
    assign w_w_go  = ~ARESET & (r_wstate == W_ACTIVE) & W_REQ_M[r_w_owner] & (~WVALID_S | WREADY_S);

    always_comb begin
        AR_GRANT_M = '0;
        AW_GRANT_M = '0;
        W_GRANT_M  = '0;
        if (w_ar_go) AR_GRANT_M[w_ar_idx]  = 1'b1;
        if (w_aw_go) AW_GRANT_M[w_aw_idx]  = 1'b1;
        if (w_w_go)  W_GRANT_M[r_w_owner]  = 1'b1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ARVALID_S <= 1'b0;
            ARID_S    <= '0;
            ARADDR_S  <= '0;
            ARLEN_S   <= '0;
            ARSIZE_S  <= '0;
            ARBURST_S <= '0;
            r_ar_ptr  <= '0;
        end else if (w_ar_go) begin
            ARVALID_S <= 1'b1;
            ARID_S    <= IDS_WIDTH'({w_ar_idx, w_ar_pl[AP-1 -: ID_WIDTH]});
            {ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} <= w_ar_pl[AP-ID_WIDTH-1:0];
            r_ar_ptr  <= rr_next(w_ar_idx);
        end else if (ARREADY_S) begin
            ARVALID_S <= 1'b0;
        end
    end

    // AW register, W register and the W ownership FSM share one process so the
    // AW grant and the W lock are updated together.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_w_owner <= '0;
            r_aw_ptr  <= '0;
            AWVALID_S <= 1'b0;
            AWID_S    <= '0;
            AWADDR_S  <= '0;
            AWLEN_S   <= '0;
            AWSIZE_S  <= '0;
            AWBURST_S <= '0;
            WVALID_S  <= 1'b0;
            WDATA_S   <= '0;
            WSTRB_S   <= '0;
            WLAST_S   <= 1'b0;
        end else begin
            if (w_aw_go) begin
                AWVALID_S <= 1'b1;
                AWID_S    <= IDS_WIDTH'({w_aw_idx, w_aw_pl[AP-1 -: ID_WIDTH]});
                {AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S} <= w_aw_pl[AP-ID_WIDTH-1:0];
                r_aw_ptr  <= rr_next(w_aw_idx);
            end else if (AWREADY_S) begin
                AWVALID_S <= 1'b0;
            end

            if (w_w_go) begin
                WVALID_S <= 1'b1;
                {WDATA_S, WSTRB_S, WLAST_S} <= w_w_pl;
            end else if (WREADY_S) begin
                WVALID_S <= 1'b0;
            end

            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_go) begin
                        r_wstate  <= W_ACTIVE;
                        r_w_owner <= w_aw_idx;
                    end
                end
                W_ACTIVE: begin
                    if (w_w_go && w_w_pl[0]) r_wstate <= W_LAST;
                end
                W_LAST: begin
                    if (WVALID_S && WREADY_S && WLAST_S) r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // The whole ID prefix is checked so out-of-range destinations are dropped.
    assign w_r_hi   = RID_S[IDS_WIDTH-1:ID_WIDTH];
    assign w_b_hi   = BID_S[IDS_WIDTH-1:ID_WIDTH];
    assign w_r_keep = 32'(w_r_hi) < 32'(masters);
    assign w_b_keep = 32'(w_b_hi) < 32'(masters);
    assign RREADY_S = ~R_VALID_X | (R_READY_X[R_DEST_X] & R_VALID_X);
    assign BREADY_S = ~B_VALID_X | (B_READY_X[B_DEST_X] & B_VALID_X);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            R_VALID_X   <= 1'b0;
            R_DEST_X    <= '0;
            R_PAYLOAD_X <= '0;
        end else if (RVALID_S && RREADY_S) begin
            R_VALID_X   <= w_r_keep;
            R_DEST_X    <= RID_S[ID_WIDTH +: MW];
            R_PAYLOAD_X <= {RID_S[ID_WIDTH-1:0], RDATA_S, RRESP_S, RLAST_S};
        end else if (R_READY_X[R_DEST_X]) begin
            R_VALID_X   <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            B_VALID_X   <= 1'b0;
            B_DEST_X    <= '0;
            B_PAYLOAD_X <= '0;
        end else if (BVALID_S && BREADY_S) begin
            B_VALID_X   <= w_b_keep;
            B_DEST_X    <= BID_S[ID_WIDTH +: MW];
            B_PAYLOAD_X <= {BID_S[ID_WIDTH-1:0], BRESP_S};
        end else if (B_READY_X[B_DEST_X]) begin
            B_VALID_X   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xbar_master_interface.sv
// Directed bench for xbar_master_interface with 2 masters and default widths.
module tb_xbar_master_interface;

    localparam int AP = 45;
    localparam int WP = 37;
    localparam int RP = 39;
    localparam int BP = 6;

    logic                ACLK = 1'b0;
    logic                ARESET;
    logic [1:0]          AR_REQ_M, AW_REQ_M, W_REQ_M;
    logic [1:0][0:0]     AR_DEST_M, AW_DEST_M;
    logic [1:0][AP-1:0]  AR_PAYLOAD_M, AW_PAYLOAD_M;
    logic [1:0][WP-1:0]  W_PAYLOAD_M;
    logic [1:0]          AR_GRANT_M, AW_GRANT_M, W_GRANT_M;
    logic                R_VALID_X, B_VALID_X;
    logic [1:0]          R_READY_X, B_READY_X;
    logic [0:0]          R_DEST_X, B_DEST_X;
    logic [RP-1:0]       R_PAYLOAD_X;
    logic [BP-1:0]       B_PAYLOAD_X;
    logic [7:0]          ARID_S, AWID_S, RID_S, BID_S;
    logic [31:0]         ARADDR_S, AWADDR_S, WDATA_S, RDATA_S;
    logic [3:0]          ARLEN_S, AWLEN_S, WSTRB_S;
    logic [2:0]          ARSIZE_S, AWSIZE_S;
    logic [1:0]          ARBURST_S, AWBURST_S, RRESP_S, BRESP_S;
    logic                ARVALID_S, ARREADY_S, AWVALID_S, AWREADY_S;
    logic                WLAST_S, WVALID_S, WREADY_S;
    logic                RLAST_S, RVALID_S, RREADY_S, BVALID_S, BREADY_S;

    int n_checks = 0;
    int n_err    = 0;

    xbar_master_interface #(.masters(2), .i_am_slave_number(0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AR_REQ_M(AR_REQ_M), .AR_DEST_M(AR_DEST_M), .AR_PAYLOAD_M(AR_PAYLOAD_M), .AR_GRANT_M(AR_GRANT_M),
        .AW_REQ_M(AW_REQ_M), .AW_DEST_M(AW_DEST_M), .AW_PAYLOAD_M(AW_PAYLOAD_M), .AW_GRANT_M(AW_GRANT_M),
        .W_REQ_M(W_REQ_M), .W_PAYLOAD_M(W_PAYLOAD_M), .W_GRANT_M(W_GRANT_M),
        .R_VALID_X(R_VALID_X), .R_READY_X(R_READY_X), .R_DEST_X(R_DEST_X), .R_PAYLOAD_X(R_PAYLOAD_X),
        .B_VALID_X(B_VALID_X), .B_READY_X(B_READY_X), .B_DEST_X(B_DEST_X), .B_PAYLOAD_X(B_PAYLOAD_X),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AP-1:0] mk_a(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        return {id, addr, len, 3'd2, 2'd1};
    endfunction

    logic [7:0]  exp_arid [3] = '{8'h0A, 8'h15, 8'h0A};
    logic [31:0] exp_addr [3] = '{32'h1000, 32'h2000, 32'h1000};
    logic [31:0] wd;

    initial begin
        ARESET = 1'b1;
        AR_REQ_M = '0; AW_REQ_M = '0; W_REQ_M = '0;
        AR_DEST_M = '0; AW_DEST_M = '0;
        AR_PAYLOAD_M[0] = mk_a(4'hA, 32'h1000, 4'd0);
        AR_PAYLOAD_M[1] = mk_a(4'h5, 32'h2000, 4'd0);
        AW_PAYLOAD_M[0] = mk_a(4'h2, 32'h4000, 4'd0);
        AW_PAYLOAD_M[1] = mk_a(4'h7, 32'h3000, 4'd3);
        W_PAYLOAD_M = '0;
        R_READY_X = '0; B_READY_X = '0;
        ARREADY_S = 1'b0; AWREADY_S = 1'b0; WREADY_S = 1'b0;
        RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0;
        BID_S = '0; BRESP_S = '0; BVALID_S = 1'b0;

        // Reset state: requests present but nothing granted
        #2;
        AR_REQ_M = 2'b11; AW_REQ_M = 2'b11;
        settle;
        chk("rst_ar_grant", AR_GRANT_M, 2'b00);
        chk("rst_aw_grant", AW_GRANT_M, 2'b00);
        chk("rst_valids", {ARVALID_S, AWVALID_S, WVALID_S, R_VALID_X, B_VALID_X}, 5'b0);
        chk("rst_rready", RREADY_S, 1'b1);
        chk("rst_bready", BREADY_S, 1'b1);
        tick; tick;
        ARESET = 1'b0; AR_REQ_M = '0; AW_REQ_M = '0;

        // Round-robin AR with both masters requesting every cycle
        ARREADY_S = 1'b1; AR_REQ_M = 2'b11;
        for (int k = 0; k < 3; k++) begin
            settle;
            chk("rr_ar_grant", AR_GRANT_M, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick;
            chk("rr_arid", ARID_S, exp_arid[k]);
            chk("rr_arid_m", ARID_S[5:4], 2'(k % 2));
            chk("rr_araddr", ARADDR_S, exp_addr[k]);
        end

        // AR backpressure: register holds, no grants
        ARREADY_S = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle;
            chk("bp_ar_grant", AR_GRANT_M, 2'b00);
            tick;
            chk("bp_araddr", ARADDR_S, 32'h1000);
            chk("bp_arvalid", ARVALID_S, 1'b1);
        end
        ARREADY_S = 1'b1;
        settle;
        chk("bp_release_grant", AR_GRANT_M, 2'b10);
        tick;
        chk("bp_release_addr", ARADDR_S, 32'h2000);
        chk("bp_release_id", ARID_S, 8'h15);
        AR_REQ_M = '0;
        settle;
        chk("ar_idle_grant", AR_GRANT_M, 2'b00);
        tick;
        chk("ar_drained", ARVALID_S, 1'b0);

        // AW from M1 with a 4-beat burst, M0 AW waits
        AWREADY_S = 1'b1; WREADY_S = 1'b1;
        AW_REQ_M = 2'b10;
        settle;
        chk("aw1_grant", AW_GRANT_M, 2'b10);
        tick;
        chk("aw1_valid", AWVALID_S, 1'b1);
        chk("aw1_id", AWID_S, 8'h17);
        chk("aw1_len", AWLEN_S, 4'd3);
        AW_REQ_M = 2'b01;
        W_REQ_M = 2'b01;
        W_PAYLOAD_M[0] = {32'hBAD, 4'hF, 1'b1};
        settle;
        chk("w_nonowner", W_GRANT_M, 2'b00);
        chk("aw_busy", AW_GRANT_M, 2'b00);
        tick;
        W_REQ_M = 2'b11;
        for (int b = 0; b < 4; b++) begin
            wd = 32'hD0 + 32'(b);
            W_PAYLOAD_M[1] = {wd, 4'hF, (b == 3)};
            settle;
            chk("w_grant", W_GRANT_M, 2'b10);
            chk("w_aw_blocked", AW_GRANT_M, 2'b00);
            tick;
            chk("w_data", WDATA_S, wd);
            chk("w_last", WLAST_S, (b == 3));
        end
        WREADY_S = 1'b0;
        settle;
        chk("wlast_no_wgrant", W_GRANT_M, 2'b00);
        chk("wlast_no_awgrant", AW_GRANT_M, 2'b00);
        tick;
        chk("wlast_hold", WVALID_S, 1'b1);
        WREADY_S = 1'b1; W_REQ_M = '0;
        settle;
        chk("wlast_hs_no_aw", AW_GRANT_M, 2'b00);
        tick;
        chk("w_drained", WVALID_S, 1'b0);
        settle;
        chk("aw0_grant", AW_GRANT_M, 2'b01);
        AWREADY_S = 1'b0;
        tick;
        chk("aw0_id", AWID_S, 8'h02);
        AW_REQ_M = '0;

        // Reset while W ACTIVE with every output register full
        W_REQ_M = 2'b01; W_PAYLOAD_M[0] = {32'h55, 4'h1, 1'b0};
        AR_REQ_M = 2'b01; ARREADY_S = 1'b0;
        RVALID_S = 1'b1; RID_S = 8'h02; R_READY_X = '0;
        settle;
        chk("pre_w_grant", W_GRANT_M, 2'b01);
        chk("pre_ar_grant", AR_GRANT_M, 2'b01);
        tick;
        W_REQ_M = '0; AR_REQ_M = '0; RVALID_S = 1'b0; WREADY_S = 1'b0;
        chk("pre_valids", {ARVALID_S, AWVALID_S, WVALID_S, R_VALID_X}, 4'b1111);
        AW_PAYLOAD_M[0] = mk_a(4'h9, 32'h5000, 4'd1);
        AW_REQ_M = 2'b01;
        ARESET = 1'b1;
        settle;
        chk("arst_valids", {ARVALID_S, AWVALID_S, WVALID_S, R_VALID_X, B_VALID_X}, 5'b0);
        chk("arst_aw_grant", AW_GRANT_M, 2'b00);
        chk("arst_w_grant", W_GRANT_M, 2'b00);
        chk("arst_rready", RREADY_S, 1'b1);
        tick;
        ARESET = 1'b0;
        settle;
        chk("post_rst_aw_grant", AW_GRANT_M, 2'b01);
        tick;
        chk("post_rst_awvalid", AWVALID_S, 1'b1);
        chk("post_rst_awid", AWID_S, 8'h09);
        AW_REQ_M = '0;

        // R return path with stall, wrong-master ready and fill+drain
        RVALID_S = 1'b1; RID_S = 8'h13; RDATA_S = 32'hCAFE; RRESP_S = 2'b00; RLAST_S = 1'b1;
        R_READY_X = '0;
        settle;
        chk("r_rready_empty", RREADY_S, 1'b1);
        tick;
        chk("r_valid", R_VALID_X, 1'b1);
        chk("r_dest", R_DEST_X, 1'b1);
        chk("r_payload", R_PAYLOAD_X, {4'h3, 32'h0000CAFE, 2'b00, 1'b1});
        RDATA_S = 32'hBEEF; RLAST_S = 1'b0;
        settle;
        chk("r_rready_stall", RREADY_S, 1'b0);
        tick;
        chk("r_payload_hold", R_PAYLOAD_X, {4'h3, 32'h0000CAFE, 2'b00, 1'b1});
        R_READY_X = 2'b01;
        settle;
        chk("r_rready_wrong_m", RREADY_S, 1'b0);
        R_READY_X = 2'b10;
        settle;
        chk("r_rready_drain", RREADY_S, 1'b1);
        tick;
        chk("r_payload2", R_PAYLOAD_X, {4'h3, 32'h0000BEEF, 2'b00, 1'b0});
        chk("r_valid2", R_VALID_X, 1'b1);
        RVALID_S = 1'b0;
        tick;
        chk("r_empty", R_VALID_X, 1'b0);

        // B path: out-of-range destination is swallowed
        BVALID_S = 1'b1; BID_S = 8'h33; BRESP_S = 2'b01; B_READY_X = '0;
        settle;
        chk("b_bready_bad", BREADY_S, 1'b1);
        tick;
        chk("b_discard", B_VALID_X, 1'b0);
        settle;
        chk("b_bready_after", BREADY_S, 1'b1);
        BID_S = 8'h0E; BRESP_S = 2'b10;
        tick;
        chk("b_valid", B_VALID_X, 1'b1);
        chk("b_dest", B_DEST_X, 1'b0);
        chk("b_payload", B_PAYLOAD_X, 6'h3A);
        BVALID_S = 1'b0; B_READY_X = 2'b01;
        settle;
        chk("b_bready_drain", BREADY_S, 1'b1);
        tick;
        chk("b_empty", B_VALID_X, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
